tod_counter: RTL
================

TOD_COUNTER -- requirements
Module: tod_counter

Interface
REQ-001 Parameter CLK_DIV, default 100000000: clk cycles per one-second tick (>=2).
REQ-002 Parameter SEC_MAX, default 60: seconds modulus; SW = $clog2(SEC_MAX).
REQ-003 Parameter MIN_MAX, default 60: minutes modulus; MW = $clog2(MIN_MAX).
REQ-004 Parameter HR_MAX, default 24: hours modulus; HW = $clog2(HR_MAX).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  run enable for the tick prescaler.
REQ-008 updown  in  1  direction: 1 = count/step up, 0 = count/step down.
REQ-009 adj  in  1  adjust mode: tick suppressed, manual field stepping.
REQ-010 adj_sel  in  2  field select: 00 seconds, 01 minutes, 10 hours, 11 none.
REQ-011 adj_step  in  1  single-cycle step request for the selected field.
REQ-012 load  in  1  single-cycle parallel load of all three fields.
REQ-013 load_sec / load_min / load_hr  in  SW / MW / HW  load values.
REQ-014 alarm_en  in  1  alarm compare enable.
REQ-015 alarm_hr / alarm_min  in  HW / MW  alarm time (seconds = 0).
REQ-016 seconds / minutes / hours  out  SW / MW / HW  registered time.
REQ-017 hours12  out  4  12-hour view of hours (1..12); pm  out  1  hours >= 12.
REQ-018 tick  out  1  registered one-cycle pulse per run-mode time update.
REQ-019 day  out  1  registered one-cycle pulse on full-day wrap (either direction).
REQ-020 alarm  out  1  registered one-cycle alarm pulse.

Function
REQ-021 Priority per edge: load > adj > run; exactly one source updates time per cycle.
REQ-022 Prescaler counts 0..CLK_DIV-1 only when en=1, adj=0, load=0; otherwise held at 0.
REQ-023 Run update fires on the edge where prescaler = CLK_DIV-1; tick=1 in the following cycle, aligned with the new time.
REQ-024 Up: seconds+1; SEC_MAX-1 wraps to 0 with carry to minutes; MIN_MAX-1 wraps to 0 with carry to hours; HR_MAX-1 wraps to 0.
REQ-025 Down: seconds-1; 0 wraps to SEC_MAX-1 with borrow to minutes; same cascade into hours.
REQ-026 day=1 for one cycle when a run update moves HR_MAX-1:MIN_MAX-1:SEC_MAX-1 to 0:0:0 (up) or 0:0:0 to the max (down).
REQ-027 Adjust: on adj=1 and adj_step=1, selected field +/-1 per updown, wraps within its own modulus, no carry/borrow; adj_sel=11 no change.
REQ-028 Adjust and load never assert tick, day or alarm.
REQ-029 Load: each field takes its load value; a value >= modulus saturates to modulus-1; prescaler cleared.
REQ-030 alarm=1 for one cycle when a run update produces hours=alarm_hr, minutes=alarm_min, seconds=0 with alarm_en=1 at that edge; either direction.
REQ-031 hours12/pm combinational from hours: 0->12,pm=0; 1..11->same,pm=0; 12->12,pm=1; 13..23->hours-12,pm=1; defined only for HR_MAX=24, else hours12=0, pm=0.
REQ-032 Changing updown mid-count takes effect at the next update; prescaler phase unaffected.
REQ-033 en falling mid-second holds time and clears prescaler; restart takes a full CLK_DIV cycles to next tick.

Reset
REQ-034 rst=0 immediately clears seconds, minutes, hours, prescaler, tick, day, alarm to 0 regardless of clk.
REQ-035 First possible tick after rst release: CLK_DIV enabled cycles later; reset mid-operation discards a pending update.

Verification (CLK_DIV=4, defaults)
REQ-036 rst low, en=1, updown=1 for 4 cycles -> time 00:00:00; release -> tick every 4 cycles, seconds 1,2,3...
REQ-037 load 23:59:59, updown=1, one tick -> 00:00:00, day=1 and tick=1 same cycle; hours12=12, pm=0.
REQ-038 load 00:00:00, updown=0, one tick -> 23:59:59, day=1; hours12=11, pm=1.
REQ-039 adj=1, adj_sel=01, minutes=59, adj_step up -> minutes=0, hours unchanged, no tick; adj_sel=11 step -> no change.
REQ-040 alarm_en=1, alarm 07:30, load 07:29:59, one up tick -> 07:30:00 and alarm=1 one cycle; load 07:30:00 directly -> alarm stays 0.
REQ-041 load with load_sec=63, load_hr=30 -> seconds=59, hours=23; load and adj_step same cycle -> load wins.

Source files
------------

// File: rtl/tod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tod_counter
//  Description : Time-of-day counter (hh:mm:ss) with one-second prescaler,
//                up/down counting, manual field adjust, parallel load with
//                saturation, 12-hour view, day-wrap pulse and alarm pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tod_counter #(
    parameter int CLK_DIV = 100000000,
    parameter int SEC_MAX = 60,
    parameter int MIN_MAX = 60,
    parameter int HR_MAX  = 24,
    localparam int SW = $clog2(SEC_MAX),
    localparam int MW = $clog2(MIN_MAX),
    localparam int HW = $clog2(HR_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          updown,
    input  logic          adj,
    input  logic [1:0]    adj_sel,
    input  logic          adj_step,
    input  logic          load,
    input  logic [SW-1:0] load_sec,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hr,
    input  logic          alarm_en,
    input  logic [HW-1:0] alarm_hr,
    input  logic [MW-1:0] alarm_min,
    output logic [SW-1:0] seconds,
    output logic [MW-1:0] minutes,
    output logic [HW-1:0] hours,
    output logic [3:0]    hours12,
    output logic          pm,
    output logic          tick,
    output logic          day,
    output logic          alarm
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] c_PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] c_SEC_LAST   = SW'(SEC_MAX - 1);
    localparam logic [MW-1:0] c_MIN_LAST   = MW'(MIN_MAX - 1);
    localparam logic [HW-1:0] c_HR_LAST    = HW'(HR_MAX - 1);

    // One modular step of a field whose valid range is 0..last.
    function automatic logic [31:0] step_wrap(input logic [31:0] v,
                                              input logic [31:0] last,
                                              input logic        up);
        if (up) begin
            return (v == last) ? 32'd0 : v + 32'd1;
        end
        return (v == 32'd0) ? last : v - 32'd1;
    endfunction

    logic [PW-1:0] presc_q;
    logic [SW-1:0] seconds_q, seconds_d;
    logic [MW-1:0] minutes_q, minutes_d;
    logic [HW-1:0] hours_q,   hours_d;
    logic          tick_q, day_q, alarm_q;

    logic          run_active;
    logic          run_fire;
    logic          sec_wrap, min_wrap, hr_wrap;
    logic [SW-1:0] run_sec, adj_sec, ld_sec;
    logic [MW-1:0] run_min, adj_min, ld_min;
    logic [HW-1:0] run_hr,  adj_hr,  ld_hr;
    logic          day_d, alarm_d;

    // Run mode only when enabled and neither load nor adjust owns the cycle.
    assign run_active = en & ~adj & ~load;
    assign run_fire   = run_active & (presc_q == c_PRESC_LAST);

    // Candidate next times for each update source, then priority selection.
    always_comb begin
        // Run update: cascade carry/borrow from seconds into minutes and hours.
        sec_wrap = updown ? (seconds_q == c_SEC_LAST) : (seconds_q == '0);
        min_wrap = updown ? (minutes_q == c_MIN_LAST) : (minutes_q == '0);
        hr_wrap  = updown ? (hours_q   == c_HR_LAST)  : (hours_q   == '0);

        run_sec = SW'(step_wrap(32'(seconds_q), 32'(SEC_MAX - 1), updown));
        run_min = sec_wrap ? MW'(step_wrap(32'(minutes_q), 32'(MIN_MAX - 1), updown))
                           : minutes_q;
        run_hr  = (sec_wrap && min_wrap)
                ? HW'(step_wrap(32'(hours_q), 32'(HR_MAX - 1), updown))
                : hours_q;

        day_d   = sec_wrap & min_wrap & hr_wrap;
        alarm_d = alarm_en && (run_hr == alarm_hr) && (run_min == alarm_min)
                  && (run_sec == '0);

        // Adjust: only the selected field moves, wrapping on its own modulus.
        adj_sec = seconds_q;
        adj_min = minutes_q;
        adj_hr  = hours_q;
        if (adj_step) begin
            case (adj_sel)
                2'b00:   adj_sec = SW'(step_wrap(32'(seconds_q), 32'(SEC_MAX - 1), updown));
                2'b01:   adj_min = MW'(step_wrap(32'(minutes_q), 32'(MIN_MAX - 1), updown));
                2'b10:   adj_hr  = HW'(step_wrap(32'(hours_q),   32'(HR_MAX - 1),  updown));
                default: ;
            endcase
        end

        // Load: out-of-range values clamp to the field maximum.
        ld_sec = (32'(load_sec) >= 32'(SEC_MAX)) ? c_SEC_LAST : load_sec;
        ld_min = (32'(load_min) >= 32'(MIN_MAX)) ? c_MIN_LAST : load_min;
        ld_hr  = (32'(load_hr)  >= 32'(HR_MAX))  ? c_HR_LAST  : load_hr;

        // Priority: load, then adjust, then a firing run update.
        seconds_d = seconds_q;
        minutes_d = minutes_q;
        hours_d   = hours_q;
        if (load) begin
            seconds_d = ld_sec;
            minutes_d = ld_min;
            hours_d   = ld_hr;
        end else if (adj) begin
            seconds_d = adj_sec;
            minutes_d = adj_min;
            hours_d   = adj_hr;
        end else if (run_fire) begin
            seconds_d = run_sec;
            minutes_d = run_min;
            hours_d   = run_hr;
        end
    end

    // Prescaler: counts only in run mode, restarts from 0 otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (!run_active || run_fire) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Time registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seconds_q <= '0;
            minutes_q <= '0;
            hours_q   <= '0;
        end else begin
            seconds_q <= seconds_d;
            minutes_q <= minutes_d;
            hours_q   <= hours_d;
        end
    end

    // Event pulses, aligned with the time value produced by the run update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= 1'b0;
            day_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            tick_q  <= run_fire;
            day_q   <= run_fire & day_d;
            alarm_q <= run_fire & alarm_d;
        end
    end

    assign seconds = seconds_q;
    assign minutes = minutes_q;
    assign hours   = hours_q;
    assign tick    = tick_q;
    assign day     = day_q;
    assign alarm   = alarm_q;

    // 12-hour view exists only for a 24-hour clock.
    if (HR_MAX == 24) begin : g_12h
        // Map 0..23 onto 12,1..11 with an afternoon flag.
        always_comb begin
            hours12 = 4'd12;
            pm      = 1'b0;
            if (hours_q == '0) begin
                hours12 = 4'd12;
            end else if (hours_q < HW'(12)) begin
                hours12 = 4'(hours_q);
            end else if (hours_q == HW'(12)) begin
                hours12 = 4'd12;
                pm      = 1'b1;
            end else begin
                hours12 = 4'(hours_q - HW'(12));
                pm      = 1'b1;
            end
        end
    end else begin : g_no_12h
        assign hours12 = 4'd0;
        assign pm      = 1'b0;
    end

endmodule
`default_nettype wire
